mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Unified instruction/data memory responder for the multicycle ARM core.
//   Services one request at a time from the core's fetch/load/store path.
//   Inserts LATENCY wait states, then returns ReadData with a one-cycle MemReady pulse.
//   Reports misaligned or out-of-range accesses through MemErr.
// PARAMETERS
//   DEPTH    64  memory size in 32-bit words (power of two, 4..4096)
//   LATENCY  2   wait cycles between request acceptance and response (0..15)
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   reset      in   1   synchronous, active-high reset
//   MemReq     in   1   request valid; held with Adr/WriteData/MemWrite until MemReady
//   MemWrite   in   1   1 = store, 0 = load/fetch
//   Adr        in   32  byte address; word index = Adr[31:2]
//   WriteData  in   32  store data
//   ReadData   out  32  load/fetch data; valid when MemReady=1, held until next response
//   MemReady   out  1   one-cycle response strobe
//   MemErr     out  1   qualifies MemReady: access rejected
// BEHAVIOUR
//   - Reset: state=IDLE, MemReady=0, MemErr=0, ReadData=0, wait counter=0.
//     Array contents are not cleared.
//   - FSM states: IDLE, WAIT, RESP.
//   - IDLE: if MemReq=1, register Adr, WriteData and MemWrite.
//     Next state is WAIT with cnt=LATENCY-1, or RESP directly if LATENCY=0.
//     If MemReq=0, remain in IDLE.
//   - WAIT: decrement cnt each cycle. When cnt=0, go to RESP.
//     Inputs are ignored in WAIT.
//   - RESP: registered outputs are visible this cycle, MemReady=1; next state is IDLE.
//   - Latency: request accepted at edge T -> MemReady high during cycle T+1+LATENCY.
//     Minimum request spacing is LATENCY+2 cycles.
//   - MemReady/MemErr/ReadData are registered, set on the edge entering RESP.
//   - MemReady and MemErr drop to 0 on the edge leaving RESP. ReadData holds.
//   - Error check on captured address:
//     Adr[1:0]!=0 or Adr[31:2]>=DEPTH gives MemErr=1, ReadData=0, no array write.
//   - Store: array[idx] <= WriteData on the edge entering RESP.
//     ReadData = WriteData (write-through echo).
//   - Load: ReadData <= array[idx] on the edge entering RESP.
//   - MemReq sampled in RESP is not accepted.
//     The initiator drops MemReq after MemReady; a held MemReq is re-accepted in IDLE.
//   - Reset mid-operation (WAIT or RESP): the request is aborted.
//     No array write if the write edge has not yet occurred. No MemReady is issued.
//   - MemReq=0 in WAIT does not cancel the request; the response still issues.
// CONFIGURATION
//   MEM_BYTE_EN defined:
//   - Adds port ByteEn in 4 (bit i enables byte lane WriteData[8i+7:8i]).
//   - ByteEn is captured with the request.
//   - A store writes enabled lanes only; ByteEn=0 writes nothing, MemErr=0.
//   - ReadData on a store returns the merged word.
//   - Alignment rule is unchanged (word-aligned addresses only).
//   MEM_BYTE_EN undefined:
//   - No ByteEn port; every store writes all 32 bits.
// TESTING
//   1. LATENCY=2: store 0xDEADBEEF @0x10 at T -> MemReady=1, MemErr=0 in cycle T+3 only;
//      load @0x10 -> ReadData=0xDEADBEEF.
//   2. Load @0x13 -> MemErr=1, ReadData=0.
//      Store 0x1 @0x12 -> MemErr=1; load @0x10 still 0xDEADBEEF.
//   3. DEPTH=64: load @0x100 -> MemErr=1.
//      Load @0xFC -> MemErr=0, data from word 63.
//   4. LATENCY=0: load @0x0 accepted at T -> MemReady in T+1.
//      MemReq held through RESP -> next MemReady at T+3.
//   5. Store 0x55 @0x20 (prior 0xAA), reset asserted in WAIT cycle ->
//      no MemReady, outputs 0; later load @0x20 -> 0xAA.
//   6. MEM_BYTE_EN: store 0x11223344 ByteEn=4'hF, then 0xAABBCCDD ByteEn=4'b0010 @0x8
//      -> load @0x8 = 0x1122CC44.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory path and mem_responder.
// ByteEn exists only when MEM_BYTE_EN is defined.
interface mem_responder_if;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemErr;
`ifdef MEM_BYTE_EN
    logic [3:0]  ByteEn;

    modport master (
        output MemReq, MemWrite, Adr, WriteData, ByteEn,
        input  ReadData, MemReady, MemErr
    );
    modport slave (
        input  MemReq, MemWrite, Adr, WriteData, ByteEn,
        output ReadData, MemReady, MemErr
    );
`else
    modport master (
        output MemReq, MemWrite, Adr, WriteData,
        input  ReadData, MemReady, MemErr
    );
    modport slave (
        input  MemReq, MemWrite, Adr, WriteData,
        output ReadData, MemReady, MemErr
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding unified memory responder: LATENCY wait states, then a one-cycle
// MemReady strobe with ReadData/MemErr. Define MEM_BYTE_EN for byte-lane store enables.
module mem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] adr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH];
`ifdef MEM_BYTE_EN
    logic [3:0]  be_q;
`endif

    logic [31:0]      sel_adr;
    logic [31:0]      sel_wdata;
    logic             sel_write;
    logic [3:0]       sel_be;
    logic [IDX_W-1:0] idx;
    logic             addr_err;
    logic             enter_resp;
    logic             mem_we;
    logic [31:0]      old_word;
    logic [31:0]      merged;
    logic [31:0]      resp_data;

    // With LATENCY=0 a request is answered on its acceptance edge, so IDLE uses the live bus.
    always_comb begin
        sel_adr   = (state_q == ST_IDLE) ? bus.Adr       : adr_q;
        sel_wdata = (state_q == ST_IDLE) ? bus.WriteData : wdata_q;
        sel_write = (state_q == ST_IDLE) ? bus.MemWrite  : write_q;
`ifdef MEM_BYTE_EN
        sel_be    = (state_q == ST_IDLE) ? bus.ByteEn    : be_q;
`else
        sel_be    = 4'hF;
`endif
    end

    assign addr_err   = (sel_adr[1:0] != 2'b00) || (sel_adr[31:2] >= DEPTH_W);
    assign idx        = sel_adr[IDX_W+1:2];
    assign old_word   = mem_q[idx];
    assign enter_resp = ((state_q == ST_IDLE) && bus.MemReq && (LATENCY == 0)) ||
                        ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    assign mem_we     = enter_resp && sel_write && !addr_err && !reset;

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel_be[i]) merged[8*i +: 8] = sel_wdata[8*i +: 8];
        end
    end

    assign resp_data = addr_err ? 32'h0 : (sel_write ? merged : old_word);

    // NOTE: the storage array is deliberately not reset; contents survive a core reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= merged;
    end

    // Request capture registers only matter outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && bus.MemReq) begin
            adr_q   <= bus.Adr;
            wdata_q <= bus.WriteData;
            write_q <= bus.MemWrite;
`ifdef MEM_BYTE_EN
            be_q    <= bus.ByteEn;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ready_q <= enter_resp;
            if (enter_resp) begin
                err_q   <= addr_err;
                rdata_q <= resp_data;
            end else begin
                err_q   <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.MemReq) begin
                        if (LATENCY == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= ST_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.MemReady = ready_q;
    assign bus.MemErr   = err_q;

    a_ready_pulse: assert property (@(posedge clk) disable iff (reset) ready_q |=> !ready_q);
    a_err_qualified: assert property (@(posedge clk) disable iff (reset) err_q |-> ready_q);
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: DUT A uses LATENCY=2, DUT B uses LATENCY=0.
// Byte-enable scenarios are compiled in when MEM_BYTE_EN is defined.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH(64), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    mem_responder #(.DEPTH(64), .LATENCY(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_a [64];
    logic [31:0] model_b [64];
    bit          known_a [64];
    bit          known_b [64];

    task automatic drive(input bit on_b, input logic req, input logic wr,
                         input logic [31:0] adr, input logic [31:0] wd);
        if (on_b) begin
            bus_b.MemReq = req; bus_b.MemWrite = wr; bus_b.Adr = adr; bus_b.WriteData = wd;
        end else begin
            bus_a.MemReq = req; bus_a.MemWrite = wr; bus_a.Adr = adr; bus_a.WriteData = wd;
        end
    endtask

    function automatic logic mon_ready(input bit on_b);
        return on_b ? bus_b.MemReady : bus_a.MemReady;
    endfunction

    function automatic logic mon_err(input bit on_b);
        return on_b ? bus_b.MemErr : bus_a.MemErr;
    endfunction

    function automatic logic [31:0] mon_data(input bit on_b);
        return on_b ? bus_b.ReadData : bus_a.ReadData;
    endfunction

    // Computes the expected response from the reference array and updates it for stores.
    function automatic exp_t model_access(input bit on_b, input logic wr, input logic [31:0] adr,
                                          input logic [31:0] wd, input logic [3:0] be);
        exp_t        e;
        logic [31:0] old;
        logic [31:0] m;
        int          idx;
        e.due = 0;
        e.err = (adr[1:0] != 2'b00) || (adr[31:2] >= 30'd64);
        if (e.err) begin
            e.data = 32'h0;
        end else begin
            idx = int'(adr[7:2]);
            old = on_b ? model_b[idx] : model_a[idx];
            if (wr) begin
                m = old;
                for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
                if (on_b) begin model_b[idx] = m; known_b[idx] = 1'b1; end
                else      begin model_a[idx] = m; known_a[idx] = 1'b1; end
                e.data = m;
            end else begin
                e.data = old;
            end
        end
        return e;
    endfunction

    task automatic do_req(input bit on_b, input logic wr, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [3:0] be, input bit drop_early,
                          input string name);
        exp_t e;
        bit   got;
        int   lat;
        lat = on_b ? 0 : 2;
        e = model_access(on_b, wr, adr, wd, be);
        @(negedge clk);
        drive(on_b, 1'b1, wr, adr, wd);
`ifdef MEM_BYTE_EN
        if (on_b) bus_b.ByteEn = be; else bus_a.ByteEn = be;
`endif
        e.due = cyc + 1 + lat;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (drop_early && k == 0) drive(on_b, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
            if (mon_ready(on_b)) begin
                got = 1'b1;
                e = sb.pop_front();
                total++;
                if (cyc !== e.due) begin
                    bad++;
                    $display("FAIL %s latency: MemReady at cycle %0d, want %0d", name, cyc, e.due);
                end
                total++;
                if (mon_err(on_b) !== e.err) begin
                    bad++;
                    $display("FAIL %s MemErr: got %0b want %0b", name, mon_err(on_b), e.err);
                end
                total++;
                if (mon_data(on_b) !== e.data) begin
                    bad++;
                    $display("FAIL %s ReadData: got %08h want %08h", name, mon_data(on_b), e.data);
                end
                drive(on_b, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no MemReady within 20 cycles", name);
            if (sb.size() > 0) void'(sb.pop_front());
            drive(on_b, 1'b0, 1'b0, 32'h0, 32'h0);
        end else begin
            @(negedge clk);
            total++;
            if ({mon_ready(on_b), mon_err(on_b)} !== 2'b00) begin
                bad++;
                $display("FAIL %s pulse: MemReady/MemErr=%0b%0b after RESP, want 00",
                         name, mon_ready(on_b), mon_err(on_b));
            end
            total++;
            if (mon_data(on_b) !== e.data) begin
                bad++;
                $display("FAIL %s hold: ReadData %08h want %08h", name, mon_data(on_b), e.data);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (mon_ready(d != 0) !== 1'b0) begin
                bad++; $display("FAIL reset MemReady dut%0d: got %0b want 0", d, mon_ready(d != 0));
            end
            total++;
            if (mon_err(d != 0) !== 1'b0) begin
                bad++; $display("FAIL reset MemErr dut%0d: got %0b want 0", d, mon_err(d != 0));
            end
            total++;
            if (mon_data(d != 0) !== 32'h0) begin
                bad++; $display("FAIL reset ReadData dut%0d: got %08h want 0", d, mon_data(d != 0));
            end
        end
    endtask

    task automatic test_store_load();
        do_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, "store_10");
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "load_10");
        total++;
        if (bus_a.ReadData !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL load_10 const: got %08h want deadbeef", bus_a.ReadData);
        end
    endtask

    task automatic test_misaligned();
        do_req(1'b0, 1'b0, 32'h13, 32'h0, 4'hF, 1'b0, "load_13");
        do_req(1'b0, 1'b1, 32'h12, 32'h1, 4'hF, 1'b0, "store_12");
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "reload_10");
        total++;
        if (bus_a.ReadData !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL reload_10 const: got %08h want deadbeef", bus_a.ReadData);
        end
    endtask

    task automatic test_range();
        do_req(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, "load_100");
        do_req(1'b0, 1'b1, 32'hFC, 32'h600D_F00D, 4'hF, 1'b0, "store_fc");
        do_req(1'b0, 1'b0, 32'hFC, 32'h0, 4'hF, 1'b0, "load_fc");
        do_req(1'b0, 1'b1, 32'h8000_0010, 32'h1234, 4'hF, 1'b0, "store_high");
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "alias_10");
    endtask

    task automatic test_zero_latency();
        exp_t e;
        int   c;
        do_req(1'b1, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 1'b0, "b_store_0");
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, "b_load_0");
        // MemReq stays high through RESP: expect strobes one idle cycle apart.
        e = model_access(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        c = cyc;
        e.due = c + 1; sb.push_back(e);
        e.due = c + 3; sb.push_back(e);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (mon_ready(1'b1) !== ((k == 1) || (k == 3))) begin
                bad++; $display("FAIL held_req strobe k=%0d: got %0b", k, mon_ready(1'b1));
            end
            if (mon_ready(1'b1) && sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ((cyc !== e.due) || (mon_data(1'b1) !== e.data)) begin
                    bad++;
                    $display("FAIL held_req resp: cycle %0d data %08h want cycle %0d data %08h",
                             cyc, mon_data(1'b1), e.due, e.data);
                end
            end
            if (k == 3) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL held_req leftover: %0d expected responses not seen", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_abort();
        do_req(1'b0, 1'b1, 32'h20, 32'hAA, 4'hF, 1'b0, "store_20_aa");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h55);
`ifdef MEM_BYTE_EN
        bus_a.ByteEn = 4'hF;
`endif
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if ({mon_ready(1'b0), mon_err(1'b0), mon_data(1'b0)} !== 34'h0) begin
                bad++;
                $display("FAIL abort k=%0d: ready=%0b err=%0b data=%08h want all 0",
                         k, mon_ready(1'b0), mon_err(1'b0), mon_data(1'b0));
            end
        end
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, "load_20");
        total++;
        if (bus_a.ReadData !== 32'hAA) begin
            bad++; $display("FAIL load_20 const: got %08h want 000000aa", bus_a.ReadData);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            int          w;
            logic        wr;
            logic [31:0] a;
            w  = $urandom_range(16, 23);
            wr = ($urandom_range(0, 1) == 1) || !known_a[w];
            a  = {24'h0, w[5:0], 2'b00};
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_req(1'b0, wr, a, $urandom, 4'hF, (k % 3) == 0, "b2b");
        end
    endtask

`ifdef MEM_BYTE_EN
    task automatic test_byte_en();
        do_req(1'b0, 1'b1, 32'h8, 32'h1122_3344, 4'hF, 1'b0, "be_full");
        do_req(1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0010, 1'b0, "be_lane1");
        do_req(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, "be_load");
        total++;
        if (bus_a.ReadData !== 32'h1122_CC44) begin
            bad++; $display("FAIL be_load const: got %08h want 1122cc44", bus_a.ReadData);
        end
        do_req(1'b0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 1'b0, "be_none");
        do_req(1'b0, 1'b1, 32'h8, 32'h00EE_0000, 4'b0100, 1'b0, "be_lane2");
        do_req(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, "be_reload");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MEM_BYTE_EN
        bus_a.ByteEn = 4'hF;
        bus_b.ByteEn = 4'hF;
`endif
        test_reset();
        test_store_load();
        test_misaligned();
        test_range();
        test_zero_latency();
        test_reset_abort();
        test_back_to_back();
`ifdef MEM_BYTE_EN
        test_byte_en();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
